// File: rtl/tft_power_seq.sv
// Panel power sequencer: request -> video enable -> N frames -> PWM backlight, reversed on release.
// State-derived outputs are decoded straight from the state register; tft_bl is a registered PWM.
module tft_power_seq #(
    parameter int unsigned T_ON_DLY  = 33000,
    parameter int unsigned BL_FRAMES = 3,
    parameter int unsigned T_OFF_DLY = 33000,
    parameter logic        VS_ACTIVE = 1'b0
) (
    input  logic       tft_clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       vsync,
    input  logic [7:0] brightness,
    output logic       video_en,
    output logic       tft_bl,
    output logic       ready,
    output logic       busy,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_PWR_WAIT   = 3'd1,
        S_FRAME_WAIT = 3'd2,
        S_ON         = 3'd3,
        S_PWR_DOWN   = 3'd4
    } state_t;

    localparam logic [19:0] ON_LAST  = 20'(T_ON_DLY - 1);
    localparam logic [19:0] OFF_LAST = 20'(T_OFF_DLY - 1);
    localparam logic [7:0]  FRM_LAST = 8'(BL_FRAMES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] dly_cnt;
    logic [7:0]  frm_cnt;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty;
    logic [7:0]  duty_nxt;
    logic        vs_q;
    logic        vs_prev;
    logic        tick;
    logic        bl_en;
    logic        bl_nxt;

    always_ff @(posedge tft_clk or posedge rst) begin
        if (rst) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_q    <= vsync;
            vs_prev <= vs_q;
        end
    end

    assign tick = (vs_q == VS_ACTIVE) && (vs_prev != VS_ACTIVE);

    always_ff @(posedge tft_clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF: begin
                if (pwr_req) state_nxt = S_PWR_WAIT;
            end
            S_PWR_WAIT: begin
                if (!pwr_req)                state_nxt = S_OFF;
                else if (dly_cnt == ON_LAST) state_nxt = S_FRAME_WAIT;
            end
            S_FRAME_WAIT: begin
                // Release wins over a frame tick landing in the same cycle.
                if (!pwr_req)                         state_nxt = S_PWR_DOWN;
                else if (tick && frm_cnt == FRM_LAST) state_nxt = S_ON;
            end
            S_ON: begin
                if (!pwr_req) state_nxt = S_PWR_DOWN;
            end
            S_PWR_DOWN: begin
                if (dly_cnt == OFF_LAST) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge tft_clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= '0;
            frm_cnt <= '0;
        end else if (state_nxt != state) begin
            dly_cnt <= '0;
            frm_cnt <= '0;
        end else begin
            if (state == S_PWR_WAIT || state == S_PWR_DOWN) begin
                dly_cnt <= dly_cnt + 20'd1;
            end
            if (state == S_FRAME_WAIT && tick) begin
                frm_cnt <= frm_cnt + 8'd1;
            end
        end
    end

    // Backlight drops on the same edge that leaves ON, so gate with the next state too.
    assign bl_en    = (state == S_ON) && (state_nxt == S_ON);
    assign duty_nxt = (pwm_cnt == 8'd0) ? brightness : duty;
    assign bl_nxt   = bl_en && ((pwm_cnt < duty_nxt) || (duty_nxt == 8'hFF));

    always_ff @(posedge tft_clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            tft_bl  <= 1'b0;
        end else begin
            pwm_cnt <= bl_en ? pwm_cnt + 8'd1 : 8'd0;
            duty    <= duty_nxt;
            tft_bl  <= bl_nxt;
        end
    end

    assign video_en = (state == S_FRAME_WAIT) || (state == S_ON) || (state == S_PWR_DOWN);
    assign ready    = (state == S_ON);
    assign busy     = (state == S_PWR_WAIT) || (state == S_FRAME_WAIT) || (state == S_PWR_DOWN);
    assign state_o  = state;

endmodule

// File: tb/tb_tft_power_seq.sv
// Bench for tft_power_seq: directed sequences plus random request/brightness/reset traffic,
// every cycle compared against an age-based reference model.
module tb_tft_power_seq;

    localparam int   T_ON   = 10;
    localparam int   BLF    = 2;
    localparam int   T_OFF  = 8;
    localparam logic VS_ACT = 1'b0;

    logic       tft_clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwr_req = 1'b0;
    logic       vsync = 1'b1;
    logic [7:0] brightness = 8'd0;
    logic       video_en;
    logic       tft_bl;
    logic       ready;
    logic       busy;
    logic [2:0] state_o;

    tft_power_seq #(
        .T_ON_DLY (T_ON),
        .BL_FRAMES(BLF),
        .T_OFF_DLY(T_OFF),
        .VS_ACTIVE(VS_ACT)
    ) dut (
        .tft_clk   (tft_clk),
        .rst       (rst),
        .pwr_req   (pwr_req),
        .vsync     (vsync),
        .brightness(brightness),
        .video_en  (video_en),
        .tft_bl    (tft_bl),
        .ready     (ready),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 tft_clk = ~tft_clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         vcnt = 0;
    logic       req_g = 1'b0;
    logic [7:0] br_g = 8'd0;
    logic       ve_seen = 1'b0;
    logic       bl_seen = 1'b0;

    // Reference model: phase number, edges spent in it, frames seen, vsync history.
    int   m_st = 0;
    int   m_age = 0;
    int   m_ticks = 0;
    int   m_pd = 0;
    logic m_bl = 1'b0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_age = 0; m_ticks = 0; m_pd = 0; m_bl = 1'b0; h1 = 1'b0; h2 = 1'b0;
    endfunction

    function automatic void model_step(input logic rq, input logic vs, input logic [7:0] br);
        logic tick;
        int   nst;
        int   ph;
        tick = (h1 == VS_ACT) && (h2 != VS_ACT);
        h2 = h1;
        h1 = vs;
        nst = m_st;
        case (m_st)
            0: if (rq) nst = 1;
            1: if (!rq) nst = 0; else if (m_age == T_ON - 1) nst = 2;
            2: if (!rq) nst = 4; else if (tick && m_ticks + 1 == BLF) nst = 3;
            3: if (!rq) nst = 4;
            default: if (m_age == T_OFF - 1) nst = 0;
        endcase
        m_bl = 1'b0;
        if (m_st == 3 && nst == 3) begin
            ph = m_age % 256;
            if (ph == 0) m_pd = int'(br);
            m_bl = (ph < m_pd) || (m_pd == 255);
        end
        if (nst != m_st) begin
            m_age = 0;
            m_ticks = 0;
        end else begin
            m_age++;
            if (m_st == 2 && tick) m_ticks++;
        end
        m_st = nst;
    endfunction

    function automatic logic [31:0] m_outs();
        logic ve, rd, bs;
        ve = (m_st >= 2);
        rd = (m_st == 3);
        bs = (m_st == 1) || (m_st == 2) || (m_st == 4);
        return {25'd0, ve, m_bl, rd, bs, 3'(m_st)};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {25'd0, video_en, tft_bl, ready, busy, state_o};
    endfunction

    task automatic drive();
        vcnt++;
        vsync      = ((vcnt % 50) < 2) ? 1'b0 : 1'b1;
        pwr_req    = req_g;
        brightness = br_g;
        model_step(pwr_req, vsync, brightness);
    endtask

    task automatic step();
        @(negedge tft_clk);
        check("outs", dut_outs(), m_outs());
        ve_seen = ve_seen | video_en;
        bl_seen = bl_seen | tft_bl;
        drive();
    endtask

    task automatic wait_st(input int tgt, input int budget, input string tag, output int lat);
        lat = 0;
        while (state_o !== 3'(tgt) && lat < budget) begin
            step();
            lat++;
        end
        check(tag, 32'(state_o), 32'(tgt));
    endtask

    task automatic count_bl(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step();
            hi += int'(tft_bl);
        end
    endtask

    // Called right after a step: asserts reset mid-cycle, well clear of the next rising edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check("async_rst", dut_outs(), 32'd0);
        model_reset();
        @(negedge tft_clk);
        check("rst_hold", dut_outs(), 32'd0);
        @(negedge tft_clk);
        rst = 1'b0;
        drive();
    endtask

    function automatic logic [7:0] pick_br();
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return 8'hFF;
            2:       return 8'd64;
            3:       return 8'd128;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int lat;
        int hi;
        int n;

        #1 rst = 1'b1;
        #1 check("reset", dut_outs(), 32'd0);
        model_reset();
        @(negedge tft_clk);
        rst = 1'b0;
        drive();

        // Power-up with brightness 64.
        br_g = 8'd64;
        req_g = 1'b1;
        step();
        wait_st(1, 4, "to_pwr_wait", lat);
        check("req_to_pw_lat", 32'(lat), 32'd1);
        wait_st(2, 30, "to_frame_wait", lat);
        check("von_lat", 32'(lat), 32'(T_ON));
        check("von_level", 32'(video_en), 32'd1);
        wait_st(3, 200, "to_on", lat);
        count_bl(256, hi);
        check("duty64", 32'(hi), 32'd64);

        // Power-down from ON.
        req_g = 1'b0;
        step();
        wait_st(4, 2, "to_pwr_down", lat);
        check("pd_lat", 32'(lat), 32'd1);
        check("pd_bl_off", 32'(tft_bl), 32'd0);
        wait_st(0, 20, "to_off", lat);
        check("voff_lat", 32'(lat), 32'(T_OFF));
        check("voff_level", 32'(video_en), 32'd0);

        // Abort in PWR_WAIT at cycle 5.
        req_g = 1'b1;
        step();
        wait_st(1, 4, "abort_pw_entry", lat);
        ve_seen = 1'b0;
        repeat (4) step();
        req_g = 1'b0;
        step();
        wait_st(0, 3, "abort_pw_off", lat);
        check("abort_pw_lat", 32'(lat), 32'd1);
        repeat (3) step();
        check("abort_pw_no_video", 32'(ve_seen), 32'd0);

        // Abort in FRAME_WAIT after one tick; re-request during PWR_DOWN is ignored.
        req_g = 1'b1;
        step();
        wait_st(2, 30, "fw_entry", lat);
        bl_seen = 1'b0;
        n = 0;
        while (m_ticks < 1 && n < 200) begin
            step();
            n++;
        end
        req_g = 1'b0;
        step();
        wait_st(4, 3, "fw_abort_pd", lat);
        repeat (2) step();
        req_g = 1'b1;
        repeat (3) step();
        check("pd_ignores_req", 32'(state_o), 32'd4);
        wait_st(0, 10, "pd_to_off", lat);
        wait_st(1, 3, "restart_pw", lat);
        check("restart_lat", 32'(lat), 32'd1);
        check("fw_abort_no_bl", 32'(bl_seen), 32'd0);

        // Brightness limits and mid-period change.
        br_g = 8'd0;
        wait_st(3, 300, "on_for_duty0", lat);
        count_bl(256, hi);
        check("duty0", 32'(hi), 32'd0);
        br_g = 8'hFF;
        repeat (256) step();
        count_bl(256, hi);
        check("duty255", 32'(hi), 32'd256);
        br_g = 8'd64;
        repeat (256) step();
        n = 0;
        while ((m_age % 256) != 100 && n < 300) begin
            step();
            n++;
        end
        br_g = 8'd128;
        count_bl(100, hi);
        check("mid_change_deferred", 32'(hi), 32'd0);
        count_bl(256, hi);
        check("duty128", 32'(hi), 32'd128);

        // Asynchronous reset in ON, then rerun.
        do_reset();
        wait_st(1, 3, "rst_on_pw", lat);
        check("rst_on_pw_lat", 32'(lat), 32'd1);
        wait_st(2, 30, "rst_on_fw", lat);
        check("rst_on_von_lat", 32'(lat), 32'(T_ON));
        wait_st(3, 200, "rst_on_on", lat);

        // Asynchronous reset mid-PWR_DOWN, then rerun.
        req_g = 1'b0;
        step();
        repeat (3) step();
        check("mid_pd_state", 32'(state_o), 32'd4);
        req_g = 1'b1;
        do_reset();
        wait_st(1, 3, "rst_pd_pw", lat);
        wait_st(2, 30, "rst_pd_fw", lat);
        check("rst_pd_von_lat", 32'(lat), 32'(T_ON));
        wait_st(3, 200, "rst_pd_on", lat);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            req_g = 1'($urandom_range(0, 1));
            br_g  = pick_br();
            repeat ($urandom_range(1, 300)) begin
                step();
                if ($urandom_range(0, 63) == 0) br_g = pick_br();
            end
            if ($urandom_range(0, 9) == 0) do_reset();
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
